// File: rtl/sipo_frame_ctrl_pkg.sv
// Shared definitions for the SIPO frame controller: FSM state encoding and default word width.
package sipo_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/sipo_frame_ctrl_shift_reg.sv
// Serial-in/parallel-out shift register; direction selects where the first bit lands.
module sipo_shift_reg
  import sipo_frame_ctrl_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter bit FIRST_AT_LSB = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  generate
    if (FIRST_AT_LSB) begin : g_lsb
      assign q_d = {sin, q_q[WIDTH-1:1]};
    end else begin : g_msb
      assign q_d = {q_q[WIDTH-2:0], sin};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else if (en) begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frames a serial bit stream into WIDTH-bit words and hands them out on a valid/ready handshake.
module sipo_frame_ctrl
  import sipo_frame_ctrl_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter bit FIRST_AT_LSB = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             busy,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;
  logic             shift_en;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] word_next;

  assign shift_en = (state_q == ST_SHIFT) && sin_valid && !frame_start;

  sipo_shift_reg #(
    .WIDTH       (WIDTH),
    .FIRST_AT_LSB(FIRST_AT_LSB)
  ) u_shift (
    .clk  (clk),
    .reset(reset),
    .en   (shift_en),
    .sin  (sin),
    .q    (shift_q)
  );

  // Word as it will stand after the completing bit, so dout can be registered on that same edge.
  generate
    if (FIRST_AT_LSB) begin : g_word_lsb
      assign word_next = {sin, shift_q[WIDTH-1:1]};
    end else begin : g_word_msb
      assign word_next = {shift_q[WIDTH-2:0], sin};
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = overrun_q;
    unique case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (frame_start) begin
          cnt_d = '0;
        end else if (sin_valid) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d      = ST_HOLD;
            dout_d       = word_next;
            dout_valid_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (sin_valid) begin
          overrun_d = 1'b1;
        end
        if (dout_ready) begin
          state_d      = ST_IDLE;
          dout_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Bench for sipo_frame_ctrl: LSB-first and MSB-first instances driven in lockstep against a bit-queue model.
module tb_sipo_frame_ctrl;

  localparam int W = 4;

  logic clk = 1'b0;
  logic reset, frame_start, sin, sin_valid, dout_ready;
  logic busy_l, dout_valid_l, overrun_l;
  logic busy_m, dout_valid_m, overrun_m;
  logic [W-1:0] dout_l, dout_m;
  logic [W+2:0] obs_l, obs_m;

  int errors = 0;
  int checks = 0;

  // Reference model: the bits of the current frame in arrival order, plus the handshake flags.
  bit           m_collect, m_hold, m_valid, m_ovr;
  bit           m_bits[$];
  logic [W-1:0] m_word_l, m_word_m;

  always #5 clk = ~clk;

  sipo_frame_ctrl #(.WIDTH(W), .FIRST_AT_LSB(1'b1)) u_lsb (
    .clk(clk), .reset(reset), .frame_start(frame_start), .sin(sin), .sin_valid(sin_valid),
    .busy(busy_l), .dout(dout_l), .dout_valid(dout_valid_l), .dout_ready(dout_ready),
    .overrun(overrun_l)
  );

  sipo_frame_ctrl #(.WIDTH(W), .FIRST_AT_LSB(1'b0)) u_msb (
    .clk(clk), .reset(reset), .frame_start(frame_start), .sin(sin), .sin_valid(sin_valid),
    .busy(busy_m), .dout(dout_m), .dout_valid(dout_valid_m), .dout_ready(dout_ready),
    .overrun(overrun_m)
  );

  assign obs_l = {busy_l, dout_valid_l, overrun_l, dout_l};
  assign obs_m = {busy_m, dout_valid_m, overrun_m, dout_m};

  function automatic logic [W-1:0] word_of(input bit lsb_first);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (lsb_first) w[i] = m_bits[i];
      else           w[W-1-i] = m_bits[i];
    end
    return w;
  endfunction

  function automatic logic [W+2:0] exp_l();
    return {m_collect | m_hold, m_valid, m_ovr, m_word_l};
  endfunction

  function automatic logic [W+2:0] exp_m();
    return {m_collect | m_hold, m_valid, m_ovr, m_word_m};
  endfunction

  task automatic model_reset();
    m_collect = 0; m_hold = 0; m_valid = 0; m_ovr = 0;
    m_bits.delete();
    m_word_l = '0; m_word_m = '0;
  endtask

  task automatic model_step();
    if (m_hold) begin
      if (sin_valid) m_ovr = 1;
      if (dout_ready) begin m_hold = 0; m_valid = 0; end
    end else if (m_collect) begin
      if (frame_start) m_bits.delete();
      else if (sin_valid) begin
        m_bits.push_back(sin);
        if (m_bits.size() == W) begin
          m_word_l = word_of(1'b1);
          m_word_m = word_of(1'b0);
          m_valid = 1; m_hold = 1; m_collect = 0;
        end
      end
    end else if (frame_start) begin
      m_collect = 1;
      m_bits.delete();
    end
  endtask

  // One clock: apply inputs, let the edge happen, advance the model, settle 1 time unit past the edge.
  task automatic cycle(input logic f, input logic v, input logic s, input logic r);
    frame_start = f; sin_valid = v; sin = s; dout_ready = r;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send_bits(input logic [W-1:0] bits, input int gap);
    for (int i = 0; i < W; i++) begin
      cycle(1'b0, 1'b1, bits[W-1-i], 1'b0);
      if (i != W - 1)
        for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_start = 0; sin_valid = 0; sin = 0; dout_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs_l !== '0 || obs_m !== '0) begin
      errors++; $display("FAIL reset_state: got lsb=%b msb=%b want all zero", obs_l, obs_m);
    end
    reset = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (busy_l !== 1'b1 || busy_m !== 1'b1) begin
      errors++; $display("FAIL reset_busy_before: got %b/%b want 1/1", busy_l, busy_m);
    end
    #2 reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (obs_l !== '0 || obs_m !== '0) begin
      errors++; $display("FAIL reset_async: got lsb=%b msb=%b want all zero", obs_l, obs_m);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(4'b1111, 0);
    checks++;
    if (dout_l !== 4'hF || dout_m !== 4'hF || dout_valid_l !== 1'b1) begin
      errors++; $display("FAIL reset_fresh_frame: got %h/%h v=%b want F/F v=1", dout_l, dout_m, dout_valid_l);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_basic();
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (obs_l !== exp_l() || obs_m !== exp_m()) begin
      errors++; $display("FAIL basic_start_bit_ignored: got %b/%b want %b/%b", obs_l, obs_m, exp_l(), exp_m());
    end
    send_bits(4'b1011, 0);
    checks++;
    if (dout_l !== 4'b1101 || dout_m !== 4'b1011 || dout_valid_l !== 1'b1 || dout_valid_m !== 1'b1) begin
      errors++; $display("FAIL basic_word: got %b/%b v=%b%b want 1101/1011 v=11", dout_l, dout_m, dout_valid_l, dout_valid_m);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (busy_l !== 1'b0 || dout_valid_l !== 1'b0 || dout_l !== 4'b1101 || obs_m !== exp_m()) begin
      errors++; $display("FAIL basic_handshake: got lsb=%b msb=%b want busy=0 valid=0 dout=1101", obs_l, obs_m);
    end
  endtask

  task automatic test_gapped_backpressure();
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    send_bits(4'b1011, 3);
    checks++;
    if (dout_l !== 4'b1101 || dout_m !== 4'b1011 || dout_valid_l !== 1'b1) begin
      errors++; $display("FAIL gapped_word: got %b/%b v=%b want 1101/1011 v=1", dout_l, dout_m, dout_valid_l);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (dout_valid_l !== 1'b1 || dout_l !== 4'b1101 || dout_m !== 4'b1011 || busy_m !== 1'b1) begin
        errors++; $display("FAIL backpressure_stable[%0d]: got %b/%b v=%b want 1101/1011 v=1", i, dout_l, dout_m, dout_valid_l);
      end
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs_l !== exp_l() || obs_m !== exp_m() || busy_l !== 1'b0) begin
      errors++; $display("FAIL backpressure_release: got %b/%b want %b/%b", obs_l, obs_m, exp_l(), exp_m());
    end
  endtask

  task automatic test_overrun();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(4'b1011, 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (overrun_l !== 1'b1 || overrun_m !== 1'b1 || dout_l !== 4'b1101 || dout_m !== 4'b1011) begin
      errors++; $display("FAIL overrun_set: got ovr=%b%b dout=%b/%b want ovr=11 dout=1101/1011", overrun_l, overrun_m, dout_l, dout_m);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(4'b0001, 0);
    checks++;
    if (dout_l !== 4'b1000 || dout_m !== 4'b0001 || overrun_l !== 1'b1 || overrun_m !== 1'b1) begin
      errors++; $display("FAIL overrun_sticky: got dout=%b/%b ovr=%b%b want 1000/0001 ovr=11", dout_l, dout_m, overrun_l, overrun_m);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_restart();
    reset = 1'b1; #1; model_reset();
    @(posedge clk); #1; reset = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    send_bits(4'b0101, 0);
    checks++;
    if (dout_l !== 4'b1010 || dout_m !== 4'b0101 || dout_valid_l !== 1'b1 || overrun_l !== 1'b0) begin
      errors++; $display("FAIL restart_word: got %b/%b v=%b ovr=%b want 1010/0101 v=1 ovr=0", dout_l, dout_m, dout_valid_l, overrun_l);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 7) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 2) == 0));
      checks++;
      if (obs_l !== exp_l() || obs_m !== exp_m()) begin
        errors++; $display("FAIL random[%0d]: got %b/%b want %b/%b", n, obs_l, obs_m, exp_l(), exp_m());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped_backpressure();
    test_overrun();
    test_restart();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
